// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Watches the three lamp signals of a traffic light and checks them against the
// legal sequence RED -> RED+YELLOW -> GREEN -> YELLOW -> RED. Every phase has a
// nominal length T and may deviate by +/-TOL cycles. The monitor measures each
// phase, reports the length of every completed phase, counts full light cycles,
// and latches a sticky fault with a cause code when the light misbehaves.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   red        : observed red lamp
//   yellow     : observed yellow lamp
//   green      : observed green lamp
//   clr_fault  : level clear of a sticky fault (returns the FSM to UNSYNC)
//   phase      : FSM state, 0 UNSYNC, 1 RED, 2 RED_YEL, 3 GREEN, 4 YEL, 7 FAULT
//   dur_cnt    : cycles spent in the current phase (0 in UNSYNC/FAULT)
//   last_dur   : length of the last completed phase
//   dur_strobe : one-cycle pulse in the cycle last_dur takes a new value
//   cycle_cnt  : completed YEL -> RED transitions, wraps at 255
//   fault      : sticky fault flag
//   fault_code : 0 none, 1 illegal pattern, 2 wrong order, 3 too short,
//                4 too long
//
// Handshake: none; all inputs are sampled every cycle, all outputs are registered.
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int T_RED   = 31,
    parameter int T_RY    = 3,
    parameter int T_GREEN = 20,
    parameter int T_YEL   = 3,
    parameter int TOL     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       clr_fault,
    output logic [2:0] phase,
    output logic [7:0] dur_cnt,
    output logic [7:0] last_dur,
    output logic       dur_strobe,
    output logic [7:0] cycle_cnt,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [2:0] {
        ST_UNSYNC = 3'd0,
        ST_RED    = 3'd1,
        ST_RY     = 3'd2,
        ST_GREEN  = 3'd3,
        ST_YEL    = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    // Registers
    logic [2:0] s_lights_q;
    state_e     state_q,      state_d;
    logic [7:0] dur_cnt_q,    dur_cnt_d;
    logic [7:0] last_dur_q,   last_dur_d;
    logic       dur_strobe_q, dur_strobe_d;
    logic [7:0] cycle_cnt_q,  cycle_cnt_d;
    logic       fault_q,      fault_d;
    logic [2:0] fault_code_q, fault_code_d;
    // Set for the first phase after leaving UNSYNC: its length is unknown
    // because the phase may have started before the monitor synced.
    logic       first_q,      first_d;

    // Decoded sample
    state_e     pat_state;
    logic       pat_illegal;
    logic       pat_off;

    // Phase length window for the current state
    logic [31:0] dur_ext;
    logic [31:0] t_lo;
    logic [31:0] t_hi;

    // Nominal phase length of a synced state.
    function automatic logic [31:0] t_nom(input state_e s);
        case (s)
            ST_RED:   return 32'(T_RED);
            ST_RY:    return 32'(T_RY);
            ST_GREEN: return 32'(T_GREEN);
            ST_YEL:   return 32'(T_YEL);
            default:  return 32'd0;
        endcase
    endfunction

    // Successor of a synced state in the legal order.
    function automatic state_e next_in_order(input state_e s);
        case (s)
            ST_RED:   return ST_RY;
            ST_RY:    return ST_GREEN;
            ST_GREEN: return ST_YEL;
            ST_YEL:   return ST_RED;
            default:  return ST_UNSYNC;
        endcase
    endfunction

    // Decode the sampled {r,y,g}; OFF maps onto the UNSYNC encoding.
    always_comb begin
        pat_state   = ST_UNSYNC;
        pat_illegal = 1'b0;
        case (s_lights_q)
            3'b000:  pat_state   = ST_UNSYNC;
            3'b100:  pat_state   = ST_RED;
            3'b110:  pat_state   = ST_RY;
            3'b001:  pat_state   = ST_GREEN;
            3'b010:  pat_state   = ST_YEL;
            default: pat_illegal = 1'b1;
        endcase
    end

    assign pat_off = !pat_illegal && (pat_state == ST_UNSYNC);
    assign dur_ext = {24'd0, dur_cnt_q};
    assign t_lo    = t_nom(state_q) - 32'(TOL);
    assign t_hi    = t_nom(state_q) + 32'(TOL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            s_lights_q   <= 3'b000;
            state_q      <= ST_UNSYNC;
            dur_cnt_q    <= 8'd0;
            last_dur_q   <= 8'd0;
            dur_strobe_q <= 1'b0;
            cycle_cnt_q  <= 8'd0;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
            first_q      <= 1'b0;
        end else begin
            s_lights_q   <= {red, yellow, green};
            state_q      <= state_d;
            dur_cnt_q    <= dur_cnt_d;
            last_dur_q   <= last_dur_d;
            dur_strobe_q <= dur_strobe_d;
            cycle_cnt_q  <= cycle_cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            first_q      <= first_d;
        end
    end

    // Next-state logic
    always_comb begin
        logic [2:0] raise_code;
        raise_code   = 3'd0;
        state_d      = state_q;
        dur_cnt_d    = dur_cnt_q;
        last_dur_d   = last_dur_q;
        dur_strobe_d = 1'b0;
        cycle_cnt_d  = cycle_cnt_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        first_d      = first_q;

        case (state_q)
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d      = ST_UNSYNC;
                    fault_d      = 1'b0;
                    fault_code_d = 3'd0;
                end
            end
            ST_UNSYNC: begin
                if (pat_illegal) begin
                    raise_code = 3'd1;
                end else if (pat_state == ST_RED) begin
                    state_d   = ST_RED;
                    dur_cnt_d = 8'd1;
                    first_d   = 1'b1;
                end
            end
            default: begin
                if (pat_illegal) begin
                    raise_code = 3'd1;
                end else if (pat_off) begin
                    // Controller restart, not a fault.
                    state_d   = ST_UNSYNC;
                    dur_cnt_d = 8'd0;
                    first_d   = 1'b0;
                end else if (pat_state == state_q) begin
                    if (dur_ext == t_hi) begin
                        raise_code = 3'd4;
                    end else if (dur_cnt_q != 8'hFF) begin
                        dur_cnt_d = dur_cnt_q + 8'd1;
                    end
                end else if (pat_state == next_in_order(state_q)) begin
                    if (!first_q && (dur_ext < t_lo)) begin
                        raise_code = 3'd3;
                    end else begin
                        state_d      = pat_state;
                        dur_cnt_d    = 8'd1;
                        last_dur_d   = dur_cnt_q;
                        dur_strobe_d = 1'b1;
                        first_d      = 1'b0;
                        if (state_q == ST_YEL) begin
                            cycle_cnt_d = cycle_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    raise_code = 3'd2;
                end
            end
        endcase

        // A clear on the same edge as a new fault wins and resyncs instead.
        if (raise_code != 3'd0) begin
            dur_cnt_d = 8'd0;
            first_d   = 1'b0;
            if (clr_fault) begin
                state_d      = ST_UNSYNC;
                fault_d      = 1'b0;
                fault_code_d = 3'd0;
            end else begin
                state_d      = ST_FAULT;
                fault_d      = 1'b1;
                fault_code_d = raise_code;
            end
        end
    end

    // Outputs
    always_comb begin
        phase      = state_q;
        dur_cnt    = dur_cnt_q;
        last_dur   = last_dur_q;
        dur_strobe = dur_strobe_q;
        cycle_cnt  = cycle_cnt_q;
        fault      = fault_q;
        fault_code = fault_code_q;
    end

endmodule
